// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction-fetch PC generator, imem request/response tracking and prefetch queue
module fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [31:0]     deq_instr,
  output logic [XLEN-1:0] deq_pc,
  output logic [CW-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   pending;
  logic [CW-1:0]   drop;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic [CW+1:0]   used;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            deq_fire;
  logic [XLEN-1:0] target;
  logic            unused_redirect_lsbs;

  // Every slot is reserved at request time, so a kept response always has room.
  assign used     = (CW+2)'(pending) + (CW+2)'(drop) + (CW+2)'(count);
  assign imem_req_valid = reset && !redirect_valid && (used < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop != '0);
  assign deq_valid = (count != '0);
  assign deq_fire  = deq_valid && deq_ready && !redirect_valid;
  assign deq_instr = instr_q[rd_ptr];
  assign deq_pc    = pc_q[rd_ptr];

  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      pending  <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // Everything in flight becomes stale; a response landing now is already one of them.
      fetch_pc <= target;
      rsp_pc   <= target;
      pending  <= '0;
      drop     <= drop + pending - CW'(imem_rsp_valid);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_keep) begin
        rsp_pc <= rsp_pc + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rsp_drop) drop <= drop - CW'(1);
      pending <= pending + CW'(req_fire) - CW'(rsp_keep);
      count   <= count + CW'(rsp_keep) - CW'(deq_fire);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      instr_q[wr_ptr] <= imem_rsp_data;
      pc_q[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - table-driven and scoreboard bench for fetch_buffer
module tb_fetch_buffer;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam int          CW    = 3;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic            clk;
  logic            reset;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_valid;
  logic            deq_ready;
  logic [31:0]     deq_instr;
  logic [XLEN-1:0] deq_pc;
  logic [CW-1:0]   count;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc(deq_pc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic       drdy;
    logic       rv;
    logic       dv;
    logic [2:0] cnt;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] expq[$];
  logic [31:0] exp_fetch;
  logic [31:0] first_pc;
  int          cyc, lat, errors, checks, deq_seen, reqs;
  vec_t        tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the memory response for this cycle, then score the handshakes the next edge will take.
  task automatic eval();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (deq_valid && deq_ready && !redirect_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected: got pc %h expected no entry", deq_pc);
      end else begin
        chk("deq_pc", deq_pc, expq[0]);
        chk("deq_instr", deq_instr, expq[0]);
        void'(expq.pop_front());
      end
      if (deq_seen == 0) first_pc = deq_pc;
      deq_seen++;
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_fetch);
      expq.push_back(exp_fetch);
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_fetch = exp_fetch + 32'd4;
      reqs++;
    end
    if (redirect_valid) begin
      chk("req_valid_during_redirect", {31'd0, imem_req_valid}, 32'd0);
      expq.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      eval();
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    mq.delete();
    expq.delete();
    exp_fetch = RPC;
    deq_seen = 0;
    reqs = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; lat = 1; deq_seen = 0; reqs = 0;
    first_pc = '0;
    exp_fetch = RPC;
    tbl[0]  = '{0, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 0};
    tbl[2]  = '{0, 1, 1, 1};
    tbl[3]  = '{0, 1, 1, 2};
    tbl[4]  = '{0, 0, 1, 3};
    tbl[5]  = '{0, 0, 1, 4};
    tbl[6]  = '{0, 0, 1, 4};
    tbl[7]  = '{1, 0, 1, 4};
    tbl[8]  = '{1, 1, 1, 3};
    tbl[9]  = '{1, 1, 1, 2};
    tbl[10] = '{1, 1, 1, 2};

    reset = 1'b0; imem_req_ready = 1'b1; deq_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    #1;
    chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("reset_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_addr", imem_req_addr, RPC);

    // Backpressure then release, one table row per cycle
    do_reset();
    lat = 1;
    for (int i = 0; i < 11; i++) begin
      deq_ready = tbl[i].drdy;
      eval();
      chk($sformatf("tbl%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].rv});
      chk($sformatf("tbl%0d_deq_valid", i), {31'd0, deq_valid}, {31'd0, tbl[i].dv});
      chk($sformatf("tbl%0d_count", i), {29'd0, count}, {29'd0, tbl[i].cnt});
      if (i == 6) chk("backpressure_reqs", reqs, 32'd4);
      tick();
    end
    run(8);
    chk("backpressure_resume_seen", deq_seen, 32'd12);

    // Streaming with 1-cycle memory
    do_reset();
    lat = 1;
    deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      eval();
      chk("stream_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stream_deq_valid", {31'd0, deq_valid}, (i >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    chk("stream_deq_total", deq_seen, 32'd18);

    // Redirect with three requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    deq_ready = 1'b1;
    run(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    eval();
    tick();
    redirect_valid = 1'b0;
    deq_seen = 0;
    eval();
    chk("redir_count_next", {29'd0, count}, 32'd0);
    chk("redir_target_addr", imem_req_addr, 32'h8000_0100);
    tick();
    run(12);
    chk("redir_deq_seen", {31'd0, deq_seen > 0}, 32'd1);
    chk("redir_first_pc", first_pc, 32'h8000_0100);

    // Redirect, response and dequeue all in one cycle
    do_reset();
    lat = 1;
    deq_ready = 1'b1;
    run(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0400;
    eval();
    chk("simul_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
    chk("simul_deq_valid", {31'd0, deq_valid}, 32'd1);
    tick();
    redirect_valid = 1'b0;
    deq_seen = 0;
    eval();
    chk("simul_count_next", {29'd0, count}, 32'd0);
    chk("simul_deq_valid_next", {31'd0, deq_valid}, 32'd0);
    chk("simul_target_addr", imem_req_addr, 32'h8000_0400);
    tick();
    run(6);
    chk("simul_first_pc", first_pc, 32'h8000_0400);

    // Misaligned target, then a second redirect one cycle later
    do_reset();
    lat = 2;
    deq_ready = 1'b1;
    run(4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0206;
    eval();
    tick();
    redirect_pc = 32'h8000_0300;
    eval();
    chk("redir2_first_target_addr", imem_req_addr, 32'h8000_0204);
    tick();
    redirect_valid = 1'b0;
    deq_seen = 0;
    eval();
    chk("redir2_second_target_addr", imem_req_addr, 32'h8000_0300);
    tick();
    run(10);
    chk("redir2_deq_seen", {31'd0, deq_seen > 0}, 32'd1);
    chk("redir2_first_pc", first_pc, 32'h8000_0300);

    // Asynchronous reset with count=2, pending=1
    do_reset();
    lat = 1;
    deq_ready = 1'b0;
    run(3);
    #1;
    chk("midrst_pre_count", {29'd0, count}, 32'd2);
    reset = 1'b0;
    #1;
    chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("midrst_deq_valid", {31'd0, deq_valid}, 32'd0);
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_addr", imem_req_addr, RPC);
    do_reset();
    deq_ready = 1'b1;
    deq_seen = 0;
    eval();
    chk("midrst_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("midrst_next_addr", imem_req_addr, RPC);
    tick();
    run(6);
    chk("midrst_first_pc", first_pc, RPC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction-fetch front end for the pipelined RV32I core: it replaces the single PCF register with a PC generator, a latency-tolerant instruction-memory request/response interface and a DEPTH-entry prefetch queue. Decode drains the queue through a valid/ready handshake, where ready is the inverse of stallD. A taken branch or jump resolved in execute (PCSrcE) redirects fetch, flushes the queue and discards any in-flight responses. The block sits between instruction memory and the D-stage pipeline register.

## Interface
Parameters:
- XLEN, 32, address/PC width
- DEPTH, 4, queue entries and maximum requests in flight; power of two, at least 2
- RESET_PC, 32'h8000_0000, first fetch address after reset
- CW, $clog2(DEPTH+1), width of the counters (derived)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- imem_req_valid  out  1  request pending on imem_req_addr
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid; responses return in request order
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  redirect request from the E stage (PCSrcE)
- redirect_pc  in  XLEN  branch/jump target; bits [1:0] ignored
- deq_valid  out  1  queue head valid
- deq_ready  in  1  decode accepts the head (~stallD)
- deq_instr  out  32  head instruction
- deq_pc  out  XLEN  head PC
- count  out  CW  queue occupancy

## Operation
- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next kept response.
  - pending: live requests in flight.
  - drop: stale requests in flight.
  - Circular queue with rd_ptr/wr_ptr and count.
- Request issue:
  - imem_req_valid = !redirect_valid && (pending + drop + count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake, fetch_pc += 4 modulo 2^XLEN and pending += 1.
- Response handling:
  - If drop > 0, the word is discarded and drop -= 1.
  - Otherwise the word is written at wr_ptr with PC rsp_pc; rsp_pc += 4, pending -= 1, count += 1.
- Dequeue: on deq_valid && deq_ready, rd_ptr advances and count -= 1.
- Same-cycle enqueue and dequeue: count is unchanged.
- Redirect (redirect_valid=1, takes priority over everything else in that cycle):
  - Queue is cleared: count=0, rd_ptr=wr_ptr=0. Any dequeue that cycle has no further effect.
  - No request is issued.
  - fetch_pc and rsp_pc are set to {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_next = drop + pending − imem_rsp_valid. Any response arriving that cycle is discarded.
  - pending_next = 0.
- Back-to-back redirects accumulate drop; the invariant pending + drop + count ≤ DEPTH always holds.
- The queue never overflows: a response always finds a free entry, because of the credit rule.
- Pointers wrap modulo DEPTH. full is count==DEPTH; empty is count==0.

## Timing
- Reset values:
  - imem_req_valid=0, deq_valid=0, count=0.
  - fetch_pc=rsp_pc=RESET_PC, so imem_req_addr=RESET_PC.
  - pending=0, drop=0, pointers 0.
- First request is presented in the first cycle after reset deasserts.
- Requests:
  - imem_req_valid is combinational from registered state and redirect_valid.
  - At most one request per cycle; sustained throughput is one per cycle when imem_req_ready=1 and decode is not stalled.
- Responses:
  - Earliest response is the cycle after its request handshake. A same-cycle response is illegal.
  - A response in cycle N appears at deq_valid/deq_instr in cycle N+1. There is no bypass.
- deq_valid, deq_instr and deq_pc are driven from registered queue state and are stable while deq_ready=0.
- After a redirect in cycle N:
  - Request for the target is presented in N+1.
  - Earliest target instruction reaches deq_valid in N+3, given 1-cycle memory latency.
- Reset asserted mid-operation: all state clears immediately (asynchronous). In-flight responses arriving after reset deasserts are not tracked; the memory model must flush on reset.

## Test plan
- Streaming:
  - Stimulus: reset release, 1-cycle memory (rsp = addr), deq_ready=1.
  - Required: requests 0x8000_0000, _0004, _0008… on consecutive cycles; deq_pc/deq_instr match, one per cycle from cycle 3.
- Backpressure:
  - Stimulus: deq_ready=0 throughout.
  - Required: exactly 4 requests issued; count reaches 4; imem_req_valid stays 0. Raising deq_ready then resumes the in-order stream with no loss or duplication.
- Redirect with in-flight requests:
  - Stimulus: 3-cycle memory latency, redirect to 0x8000_0100 while pending=3.
  - Required: the 3 stale responses are dropped; first deq_pc is 0x8000_0100; count=0 in the cycle after the redirect.
- Simultaneous events:
  - Stimulus: redirect, imem_rsp_valid and deq handshake all in the same cycle.
  - Required: response discarded; queue empty next cycle; no request issued that cycle.
- Redirect details:
  - Stimulus: redirect_pc=0x8000_0206, then a second redirect to 0x8000_0300 one cycle later.
  - Required: the first target fetch address is 0x8000_0204; all responses before the second target are dropped; first deq_pc is 0x8000_0300.
- Reset mid-operation:
  - Stimulus: reset=0 while count=2 and pending=1.
  - Required: outputs return to reset values immediately; the next request is RESET_PC.
